// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control FSM: FSM states, opcode values,
// ALU operation encodings and instruction-word field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_WB       = 3'd4,
    S_WAIT_REL = 3'd5
  } state_e;

  // Instruction word layout: [7:4] opcode, [3:2] dst, [1:0] src.
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int DST_MSB = 3;
  localparam int DST_LSB = 2;
  localparam int SRC_MSB = 1;
  localparam int SRC_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_MOV = 3'd5,
    ALU_NOT = 3'd6
  } alu_op_e;

  // Opcodes 1000-1111 are all illegal, so the MSB alone identifies them.
  function automatic logic is_illegal(input logic [3:0] opc);
    return opc[3];
  endfunction

  // NOP and illegal opcodes map to ALU_ADD; they never write, so the value is inert.
  function automatic alu_op_e decode_alu(input logic [3:0] opc);
    case (opc)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_MOV:  return ALU_MOV;
      OP_NOT:  return ALU_NOT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Execute-button conditioning: two-flop synchronizer, optional debouncer and
// rising-edge detector. Define CTRL_DEBOUNCE_EN to enable the debouncer; by
// default the synchronized level is used directly.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_button,
  output logic o_level,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  // Two-flop synchronizer for the asynchronous button input.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // Accept a level change only after it persists for DEBOUNCE_CYCLES cycles; any bounce restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync2;
`endif

  // Delayed copy of the conditioned level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;

endmodule

// File: rtl/cpu_control_fsm.sv
// Control FSM for a single-step trainer CPU: each button press fetches the DIP
// instruction word, decodes it and drives one register-file write-back.
// Optional feature: define CTRL_DEBOUNCE_EN to debounce the execute button.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] trainer_dip,
  input  logic       activate_button,
  output logic [1:0] rf_raddr_a,
  output logic [1:0] rf_raddr_b,
  output logic [1:0] rf_waddr,
  output logic       rf_we,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       instr_done,
  output logic       illegal,
  output logic [7:0] instr_count
);

  state_e     r_state;
  state_e     w_next;
  logic [7:0] r_instr_q;
  logic [7:0] r_instr_count;
  logic       w_btn_level;
  logic       w_btn_rise;
  logic [3:0] w_opc;
  logic       w_illegal_op;
  logic       w_writes;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .i_button (activate_button),
    .o_level  (w_btn_level),
    .o_rise   (w_btn_rise)
  );

  assign w_opc        = r_instr_q[OPC_MSB:OPC_LSB];
  assign w_illegal_op = is_illegal(w_opc);
  assign w_writes     = !w_illegal_op && (w_opc != OP_NOP);

  // State register.
  // NOTE: reset clears control state only; the asynchronous clear makes outputs drop in the same cycle rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; requests outside IDLE are ignored.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_btn_rise) w_next = S_FETCH;
      S_FETCH:    w_next = S_DECODE;
      S_DECODE:   w_next = S_EXEC;
      S_EXEC:     w_next = S_WB;
      S_WB:       w_next = S_WAIT_REL;
      S_WAIT_REL: if (!w_btn_level) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Instruction latch (FETCH) and retired-instruction counter (WB, legal opcodes).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_q     <= '0;
      r_instr_count <= '0;
    end else begin
      if (r_state == S_FETCH) r_instr_q <= trainer_dip;
      if (r_state == S_WB && !w_illegal_op) r_instr_count <= r_instr_count + 8'd1;
    end
  end

  // Output decode from the current state and latched instruction.
  always_comb begin
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    rf_waddr   = '0;
    rf_we      = 1'b0;
    alu_op     = '0;
    busy       = (r_state != S_IDLE);
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_DECODE: begin
        rf_raddr_a = r_instr_q[DST_MSB:DST_LSB];
        rf_raddr_b = r_instr_q[SRC_MSB:SRC_LSB];
        alu_op     = decode_alu(w_opc);
      end
      S_EXEC: begin
        rf_raddr_a = r_instr_q[DST_MSB:DST_LSB];
        rf_raddr_b = r_instr_q[SRC_MSB:SRC_LSB];
        alu_op     = decode_alu(w_opc);
        illegal    = w_illegal_op;
      end
      S_WB: begin
        rf_raddr_a = r_instr_q[DST_MSB:DST_LSB];
        rf_raddr_b = r_instr_q[SRC_MSB:SRC_LSB];
        alu_op     = decode_alu(w_opc);
        rf_we      = w_writes;
        rf_waddr   = w_writes ? r_instr_q[DST_MSB:DST_LSB] : 2'd0;
        instr_done = !w_illegal_op;
      end
      default: ;
    endcase
  end

  assign instr_count = r_instr_count;

endmodule
